// File: rtl/dds_meas_pkg.sv
// Shared constants, FSM state type and mask helpers for dds_pulse_meas.
// f_abs17: 17-bit |x|; f_lowest_set / f_highest_set: 16-bit mask -> lane.
package dds_meas_pkg;

  localparam int LANES = 16;
  localparam int DW    = 16;
  localparam int CW    = 32;
  localparam int MAGW  = 17;

  typedef enum logic {
    ST_OFF,
    ST_ON
  } state_e;

  // Sign-extend before negating so |-32768| = 32768 without wrap.
  function automatic logic [MAGW-1:0] f_abs17(
    input logic signed [DW-1:0] x
  );
    logic [MAGW-1:0] e;
    e = {x[DW-1], x};
    return x[DW-1] ? (~e + 1'b1) : e;
  endfunction

  function automatic logic [3:0] f_lowest_set(
    input logic [LANES-1:0] m
  );
    logic [3:0] r;
    r = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (m[k]) r = 4'(k);
    end
    return r;
  endfunction

  function automatic logic [3:0] f_highest_set(
    input logic [LANES-1:0] m
  );
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      if (m[k]) r = 4'(k);
    end
    return r;
  endfunction

endpackage

// File: rtl/dds_pulse_meas_lane_mag.sv
// One lane: stage 1 registers |I|+|Q|, stage 2 registers mag >= thr.
// Ports: clk_i, rst_ni (sync, active-low), i_i/q_i samples, thr_i, above_o.
module dds_lane_mag
  import dds_meas_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic signed [DW-1:0] i_i,
  input  logic signed [DW-1:0] q_i,
  input  logic [MAGW-1:0]      thr_i,
  output logic                 above_o
);

  logic [MAGW-1:0] mag_d;
  logic [MAGW-1:0] mag_q;
  logic            above_d;
  logic            above_q;

  // Max sum is 65536, so 17 bits never overflow.
  always_comb begin
    mag_d   = f_abs17(i_i) + f_abs17(q_i);
    above_d = (mag_q >= thr_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mag_q   <= '0;
      above_q <= 1'b0;
    end else begin
      mag_q   <= mag_d;
      above_q <= above_d;
    end
  end

  assign above_o = above_q;

endmodule

// File: rtl/dds_pulse_meas.sv
// Pulse width / rise-to-rise period meter on 16-lane I/Q sample words.
// In: clk_user_bufg, rst_glb, s_valid, s_i, s_q, thr. Out: meas_*, pulse_cnt, in_pulse.
module dds_pulse_meas
  import dds_meas_pkg::*;
(
  input  logic                  clk_user_bufg,
  input  logic                  rst_glb,
  input  logic                  s_valid,
  input  logic [LANES*DW-1:0]   s_i,
  input  logic [LANES*DW-1:0]   s_q,
  input  logic [MAGW-1:0]       thr,
  output logic                  meas_valid,
  output logic [CW-1:0]         meas_width,
  output logic [CW-1:0]         meas_period,
  output logic                  period_valid,
  output logic [15:0]           pulse_cnt,
  output logic                  in_pulse
);

  logic [LANES-1:0] above_w;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    dds_lane_mag u_lane (
      .clk_i   (clk_user_bufg),
      .rst_ni  (rst_glb),
      .i_i     (s_i[DW*k +: DW]),
      .q_i     (s_q[DW*k +: DW]),
      .thr_i   (thr),
      .above_o (above_w[k])
    );
  end

  // Valid travels alongside the lane pipeline; the word index is
  // attached when the mask is registered for the FSM.
  logic             v1_q, v2_q, mv_q;
  logic [LANES-1:0] mask_q;
  logic [CW-1:0]    midx_q;
  logic [CW-1:0]    wcnt_q;

  always_ff @(posedge clk_user_bufg) begin
    if (!rst_glb) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      mv_q   <= 1'b0;
      mask_q <= '0;
      midx_q <= '0;
      wcnt_q <= '0;
    end else begin
      v1_q   <= s_valid;
      v2_q   <= v1_q;
      mv_q   <= v2_q;
      mask_q <= above_w;
      midx_q <= wcnt_q;
      if (v2_q) wcnt_q <= wcnt_q + 1'b1;
    end
  end

  state_e        state_q, state_d;
  logic [CW-1:0] rise_q, rise_d;
  logic [CW-1:0] prev_q, prev_d;
  logic          hasp_q, hasp_d;
  logic [CW-1:0] per_q, per_d;
  logic          pv_q, pv_d;
  logic          mvo_q, mvo_d;
  logic [CW-1:0] wid_q, wid_d;
  logic [CW-1:0] pero_q, pero_d;
  logic          pvo_q, pvo_d;
  logic [15:0]   cnt_q, cnt_d;

  logic [3:0]    lo, hi;
  logic [CW-1:0] tbase, rise_t, fall_t;
  logic [CW-1:0] e_rise, e_per;
  logic          e_pv, emit;

  always_comb begin
    state_d = state_q;
    rise_d  = rise_q;
    prev_d  = prev_q;
    hasp_d  = hasp_q;
    per_d   = per_q;
    pv_d    = pv_q;
    mvo_d   = 1'b0;
    wid_d   = wid_q;
    pero_d  = pero_q;
    pvo_d   = pvo_q;
    cnt_d   = cnt_q;
    emit    = 1'b0;
    e_rise  = rise_q;
    e_per   = per_q;
    e_pv    = pv_q;
    lo      = f_lowest_set(mask_q);
    hi      = f_highest_set(mask_q);
    tbase   = {midx_q[CW-5:0], 4'b0000};
    rise_t  = tbase | CW'(lo);
    // Fall is the first sample below threshold.
    fall_t  = (|mask_q) ? tbase + CW'(hi) + CW'(1) : tbase;

    if (mv_q) begin
      unique case (state_q)
        ST_OFF: begin
          if (|mask_q) begin
            rise_d = rise_t;
            per_d  = hasp_q ? rise_t - prev_q : '0;
            pv_d   = hasp_q;
            prev_d = rise_t;
            hasp_d = 1'b1;
            if (hi != 4'd15) begin
              emit   = 1'b1;
              e_rise = rise_t;
              e_per  = per_d;
              e_pv   = pv_d;
            end else begin
              state_d = ST_ON;
            end
          end
        end
        ST_ON: begin
          if (!(|mask_q) || hi != 4'd15) begin
            emit    = 1'b1;
            state_d = ST_OFF;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end

    if (emit) begin
      mvo_d  = 1'b1;
      wid_d  = fall_t - e_rise;
      pero_d = e_per;
      pvo_d  = e_pv;
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_user_bufg) begin
    if (!rst_glb) begin
      state_q <= ST_OFF;
      rise_q  <= '0;
      prev_q  <= '0;
      hasp_q  <= 1'b0;
      per_q   <= '0;
      pv_q    <= 1'b0;
      mvo_q   <= 1'b0;
      wid_q   <= '0;
      pero_q  <= '0;
      pvo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rise_q  <= rise_d;
      prev_q  <= prev_d;
      hasp_q  <= hasp_d;
      per_q   <= per_d;
      pv_q    <= pv_d;
      mvo_q   <= mvo_d;
      wid_q   <= wid_d;
      pero_q  <= pero_d;
      pvo_q   <= pvo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign meas_valid   = mvo_q;
  assign meas_width   = wid_q;
  assign meas_period  = pero_q;
  assign period_valid = pvo_q;
  assign pulse_cnt    = cnt_q;
  assign in_pulse     = (state_q == ST_ON);

endmodule

// File: tb/tb_dds_pulse_meas.sv
// Directed bench for dds_pulse_meas with a queue of expected measurements.
// Stimulus drives on negedge; a negedge monitor pops and compares strobes.
module tb_dds_pulse_meas;

  logic          clk_user_bufg;
  logic          rst_glb;
  logic          s_valid;
  logic [255:0]  s_i;
  logic [255:0]  s_q;
  logic [16:0]   thr;
  logic          meas_valid;
  logic [31:0]   meas_width;
  logic [31:0]   meas_period;
  logic          period_valid;
  logic [15:0]   pulse_cnt;
  logic          in_pulse;

  dds_pulse_meas dut (
    .clk_user_bufg (clk_user_bufg),
    .rst_glb       (rst_glb),
    .s_valid       (s_valid),
    .s_i           (s_i),
    .s_q           (s_q),
    .thr           (thr),
    .meas_valid    (meas_valid),
    .meas_width    (meas_width),
    .meas_period   (meas_period),
    .period_valid  (period_valid),
    .pulse_cnt     (pulse_cnt),
    .in_pulse      (in_pulse)
  );

  initial clk_user_bufg = 1'b0;
  always #5 clk_user_bufg = ~clk_user_bufg;

  typedef struct {
    int w;
    int p;
    bit pv;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   ntests = 0;
  int   nfail  = 0;
  int   exp_cnt = 0;
  int   lat;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input int w, input int p, input bit pv);
    exp_t x;
    x.w = w;
    x.p = p;
    x.pv = pv;
    sb.push_back(x);
  endtask

  always @(negedge clk_user_bufg) begin
    if (rst_glb && meas_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_meas", meas_valid, 0);
      end else begin
        e = sb.pop_front();
        exp_cnt++;
        chk("width", meas_width, e.w);
        chk("period_valid", period_valid, e.pv);
        if (e.pv) chk("period", meas_period, e.p);
        chk("pulse_cnt", pulse_cnt, exp_cnt);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk_user_bufg);
    rst_glb = 1'b0;
    s_valid = 1'b0;
    s_i = '0;
    s_q = '0;
    @(negedge clk_user_bufg);
    rst_glb = 1'b1;
    sb.delete();
    exp_cnt = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mv"}, meas_valid, 0);
    chk({tag, "_width"}, meas_width, 0);
    chk({tag, "_period"}, meas_period, 0);
    chk({tag, "_pv"}, period_valid, 0);
    chk({tag, "_cnt"}, pulse_cnt, 0);
    chk({tag, "_inp"}, in_pulse, 0);
  endtask

  // Sample t is in the pulse when start <= t mod per < start+len.
  task automatic drive_stream(input int w0, input int nw,
                              input int start, input int len,
                              input int per,
                              input logic signed [15:0] iv,
                              input logic signed [15:0] qv,
                              input bit gaps);
    logic [255:0] bi, bq;
    int t;
    for (int w = 0; w < nw; w++) begin
      for (int l = 0; l < 16; l++) begin
        t = (w0 + w) * 16 + l;
        if ((t % per) >= start && (t % per) < start + len) begin
          bi[16*l +: 16] = iv;
          bq[16*l +: 16] = qv;
        end else begin
          bi[16*l +: 16] = '0;
          bq[16*l +: 16] = '0;
        end
      end
      @(negedge clk_user_bufg);
      s_valid = 1'b1;
      s_i = bi;
      s_q = bq;
      if (gaps) begin
        @(negedge clk_user_bufg);
        s_valid = 1'b0;
        s_i = {16{16'sd4000}};
        s_q = '0;
      end
    end
    @(negedge clk_user_bufg);
    s_valid = 1'b0;
    s_i = '0;
    s_q = '0;
  endtask

  task automatic drain();
    repeat (8) @(negedge clk_user_bufg);
  endtask

  initial begin
    rst_glb = 1'b0;
    s_valid = 1'b0;
    s_i = '0;
    s_q = '0;
    thr = 17'd1000;
    repeat (2) @(negedge clk_user_bufg);
    rst_glb = 1'b1;
    chk_zero("reset");

    // Multi-word pulses: 100..139 every 160 samples.
    push(40, 0, 0);
    push(40, 160, 1);
    push(40, 160, 1);
    push(40, 160, 1);
    drive_stream(0, 40, 100, 40, 160, 16'sd4000, 16'sd0, 1'b0);
    drain();
    chk("mw_sb_empty", sb.size(), 0);
    chk("mw_cnt", pulse_cnt, 4);

    // Single-word pulse, lanes 2..9 of word 5, latency check.
    do_reset();
    thr = 17'd65535;
    push(8, 0, 0);
    drive_stream(0, 5, 0, 0, 100000, 16'sd0, 16'sd0, 1'b0);
    s_valid = 1'b1;
    for (int l = 0; l < 16; l++) begin
      s_i[16*l +: 16] = (l >= 2 && l <= 9) ? 16'sh8000 : 16'sh0000;
      s_q[16*l +: 16] = (l >= 2 && l <= 9) ? 16'sh8000 : 16'sh0000;
    end
    @(negedge clk_user_bufg);
    s_valid = 1'b0;
    s_i = '0;
    s_q = '0;
    lat = 0;
    while (!meas_valid && lat < 10) begin
      @(negedge clk_user_bufg);
      lat++;
    end
    chk("sw_latency", lat, 3);
    drain();
    chk("sw_sb_empty", sb.size(), 0);
    chk("sw_cnt", pulse_cnt, 1);

    // Threshold equality: mag = 600 + 400 = 1000.
    do_reset();
    thr = 17'd1000;
    push(48, 0, 0);
    drive_stream(0, 5, 0, 48, 100000, 16'sd600, -16'sd400, 1'b0);
    drain();
    chk("thr_eq_sb_empty", sb.size(), 0);
    chk("thr_eq_cnt", pulse_cnt, 1);

    do_reset();
    thr = 17'd1001;
    drive_stream(0, 3, 0, 48, 100000, 16'sd600, -16'sd400, 1'b0);
    drain();
    chk("thr_hi_inp", in_pulse, 0);
    chk("thr_hi_cnt", pulse_cnt, 0);

    // Same multi-word stream with invalid words interleaved.
    do_reset();
    thr = 17'd1000;
    push(40, 0, 0);
    push(40, 160, 1);
    push(40, 160, 1);
    push(40, 160, 1);
    drive_stream(0, 40, 100, 40, 160, 16'sd4000, 16'sd0, 1'b1);
    drain();
    chk("gap_sb_empty", sb.size(), 0);
    chk("gap_cnt", pulse_cnt, 4);

    // Reset while a pulse is open.
    do_reset();
    drive_stream(0, 8, 100, 40, 160, 16'sd4000, 16'sd0, 1'b0);
    repeat (4) @(negedge clk_user_bufg);
    chk("mid_inp", in_pulse, 1);
    do_reset();
    chk_zero("mid_rst");
    push(40, 0, 0);
    drive_stream(0, 10, 100, 40, 160, 16'sd4000, 16'sd0, 1'b0);
    drain();
    chk("mid_sb_empty", sb.size(), 0);
    chk("mid_cnt", pulse_cnt, 1);

    // Pulse ending on lane 15: samples 48..63.
    do_reset();
    drive_stream(0, 4, 48, 16, 100000, 16'sd4000, 16'sd0, 1'b0);
    drain();
    chk("edge_inp", in_pulse, 1);
    chk("edge_cnt0", pulse_cnt, 0);
    push(16, 0, 0);
    drive_stream(4, 1, 48, 16, 100000, 16'sd4000, 16'sd0, 1'b0);
    drain();
    chk("edge_sb_empty", sb.size(), 0);
    chk("edge_inp_off", in_pulse, 0);
    chk("edge_cnt1", pulse_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
